// File: rtl/mem_responder.sv
// Load/store responder for the RV32E core: word memory at BASE_ADDR, one request
// in flight, response after a fixed LATENCY with byte-lane placement/alignment.
module mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int          AW     = $clog2(DEPTH_WORDS) + 2;
    localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    state_t      state, nxt;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH_WORDS];

    logic        accept, misalign, in_range, err;
    logic [31:0] offset, wdata_sh;
    logic [3:0]  mask;
    logic [4:0]  shamt;
    logic [AW-3:0] idx;

    assign req_ready = rst && (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;

    // Range check is unsigned so addresses below BASE_ADDR wrap out of range.
    assign offset   = req_addr - BASE_ADDR;
    assign in_range = {1'b0, offset} < SPAN;
    assign idx      = offset[AW-1:2];
    assign shamt    = {req_addr[1:0], 3'b000};
    assign wdata_sh = req_wdata << shamt;

    always_comb begin
        misalign = 1'b0;
        mask     = 4'b1111;
        case (req_size)
            2'd0: mask = 4'b0001 << req_addr[1:0];
            2'd1: begin
                mask     = 4'b0011 << req_addr[1:0];
                misalign = req_addr[0];
            end
            2'd2: misalign = (req_addr[1:0] != 2'b00);
            default: misalign = 1'b1;
        endcase
        err = misalign || !in_range;
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE: nxt = accept ? ((LATENCY == 1) ? RESP : WAIT) : IDLE;
            WAIT: nxt = (cnt == 4'd1) ? RESP : WAIT;
            RESP: nxt = rsp_ready ? IDLE : RESP;
            default: nxt = IDLE;
        endcase
    end

    // Response data is captured at accept so later stores cannot disturb it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            cnt       <= LAT_M1;
            rsp_err   <= err;
            rsp_rdata <= (err || req_we) ? 32'd0 : (mem[idx] >> shamt);
        end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && req_we && !err) begin
            for (int b = 0; b < 4; b++)
                if (mask[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
    end
endmodule
